arm_seq: RTL and testbench

Instruction sequencer for the Harvard 16-bit core. Fetches from instruction memory, holds the program counter and instruction register, and drives the `inst` and one-hot `state` buses consumed by the ALU/writeback stage. It also resolves jumps, conditional branches and halt. It sits directly upstream of the ALU; the ALU's `wen`, `ldr` and `reg_mux` decodes depend on the `inst` and `state` it produces.

---
 rtl/arm_seq.sv | 135 +++++++++++++
 tb/tb_arm_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_seq.sv
// Instruction sequencer for the Harvard 16-bit core.
// Owns the program counter, instruction register, zero flag and retired-instruction
// counter, and walks the FETCH -> EXEC1 (-> EXEC2) phases that the ALU stage keys off.
// Jumps, zero-conditional branches and halt are resolved here, in EXEC1.
module arm_seq #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [15:0]     imem_data,
  input  logic            imem_valid,
  input  logic            alu_zero,
  output logic [15:0]     inst,
  output logic [2:0]      state,
  output logic            halted,
  output logic [15:0]     retired
);

  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

  typedef enum logic [1:0] {
    StFetch,
    StExec1,
    StExec2,
    StHalt
  } st_e;

  st_e              st_q, st_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      inst_q, inst_d;
  logic             zflag_q, zflag_d;
  logic [15:0]      retired_q, retired_d;

  // Opcode decode of the held instruction; only meaningful in EXEC1/EXEC2.
  logic [3:0]       opcode;
  logic             is_arm;
  logic             is_ldr;
  logic             is_jmp;
  logic             is_bz;
  logic             is_halt;
  logic [PC_W-1:0]  target;

  // Classify the instruction register; bits above PC_W never reach the PC.
  always_comb begin
    opcode  = inst_q[15:12];
    is_arm  = opcode[3];
    is_ldr  = (opcode == 4'hE);
    is_jmp  = (opcode == 4'h4);
    is_bz   = (opcode == 4'h5);
    is_halt = (opcode == 4'h7);
    target  = inst_q[PC_W-1:0];
  end

  // Next-state logic: every register holds unless its phase says otherwise.
  always_comb begin
    st_d      = st_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    zflag_d   = zflag_q;
    retired_d = retired_q;

    unique case (st_q)
      StFetch: begin
        // Wait states simply stall here with everything frozen.
        if (imem_valid) begin
          inst_d = imem_data;
          pc_d   = pc_q + PC_W'(1);
          st_d   = StExec1;
        end
      end

      StExec1: begin
        if (is_arm) begin
          zflag_d = alu_zero;
        end
        // BZ tests the flag left by an earlier ARM op, never this cycle's alu_zero.
        if (is_jmp || (is_bz && zflag_q)) begin
          pc_d = target;
        end
        if (is_halt) begin
          st_d = StHalt;
        end else if (is_ldr) begin
          st_d = StExec2;
        end else begin
          st_d      = StFetch;
          retired_d = retired_q + 16'd1;
        end
      end

      StExec2: begin
        retired_d = retired_q + 16'd1;
        st_d      = StFetch;
      end

      StHalt: begin
        st_d = StHalt;
      end

      default: begin
        st_d = StFetch;
      end
    endcase
  end

  // State registers; reset abandons any in-flight instruction without retiring it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= StFetch;
      pc_q      <= ResetPc;
      inst_q    <= 16'h0000;
      zflag_q   <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      st_q      <= st_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      zflag_q   <= zflag_d;
      retired_q <= retired_d;
    end
  end

  // Outputs decoded purely from registered state; no input-to-output paths.
  always_comb begin
    imem_addr = pc_q;
    inst      = inst_q;
    retired   = retired_q;
    imem_req  = (st_q == StFetch);
    halted    = (st_q == StHalt);
    state     = {(st_q == StExec2), (st_q == StExec1), (st_q == StFetch)};
  end

endmodule

// File: tb/tb_arm_seq.sv
// Directed bench for arm_seq: straight-line code, wait states, LDR, JMP, BZ,
// HALT, asynchronous reset mid-instruction, and PC wrap on a 4-bit PC instance.
module tb_arm_seq;

  logic        clk;
  logic        rst_n;
  logic        rst4_n;
  logic        imem_valid;
  logic        imem_valid4;
  logic        alu_zero;

  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [15:0] imem_data;
  logic [15:0] inst;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] retired;

  logic [3:0]  imem_addr4;
  logic        imem_req4;
  logic [15:0] imem_data4;
  logic [15:0] inst4;
  logic [2:0]  state4;
  logic        halted4;
  logic [15:0] retired4;

  logic [15:0] mem  [256];
  logic [15:0] mem4 [16];

  int total;
  int bad;

  assign imem_data  = mem[imem_addr];
  assign imem_data4 = mem4[imem_addr4];

  arm_seq #(
    .PC_W     (8),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .alu_zero   (alu_zero),
    .inst       (inst),
    .state      (state),
    .halted     (halted),
    .retired    (retired)
  );

  arm_seq #(
    .PC_W     (4),
    .RESET_PC (15)
  ) dut4 (
    .clk        (clk),
    .rst_n      (rst4_n),
    .imem_addr  (imem_addr4),
    .imem_req   (imem_req4),
    .imem_data  (imem_data4),
    .imem_valid (imem_valid4),
    .alu_zero   (1'b0),
    .inst       (inst4),
    .state      (state4),
    .halted     (halted4),
    .retired    (retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] exp_st [6];
    logic [7:0] exp_ad [6];

    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    rst4_n      = 1'b0;
    imem_valid  = 1'b1;
    imem_valid4 = 1'b1;
    alu_zero    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;

    // Straight-line code from reset.
    mem[0] = 16'h8001;
    mem[1] = 16'h0000;
    mem[2] = 16'h9002;
    #1;
    chk("rst_state", 16'(state), 16'h0001);
    chk("rst_addr", 16'(imem_addr), 16'h0000);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_retired", retired, 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0000);
    chk("rst_req", 16'(imem_req), 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    exp_st = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    exp_ad = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("line_state%0d", i), 16'(state), 16'(exp_st[i]));
      chk($sformatf("line_addr%0d", i), 16'(imem_addr), 16'(exp_ad[i]));
    end
    chk("line_retired", retired, 16'd3);
    chk("line_inst", inst, 16'h9002);

    // Wait states at pc=0.
    imem_valid = 1'b0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wait_state%0d", i), 16'(state), 16'h0001);
      chk($sformatf("wait_addr%0d", i), 16'(imem_addr), 16'h0000);
      chk($sformatf("wait_inst%0d", i), inst, 16'h0000);
    end
    imem_valid = 1'b1;
    step();
    chk("wait_cap_state", 16'(state), 16'h0002);
    chk("wait_cap_inst", inst, 16'h8001);
    chk("wait_cap_addr", 16'(imem_addr), 16'h0001);

    // LDR takes the extra EXEC2 phase and retires on leaving it.
    mem[0] = 16'hE123;
    apply_reset();
    step();
    chk("ldr_e1_state", 16'(state), 16'h0002);
    chk("ldr_e1_inst", inst, 16'hE123);
    step();
    chk("ldr_e2_state", 16'(state), 16'h0004);
    chk("ldr_e2_retired", retired, 16'd0);
    chk("ldr_e2_inst", inst, 16'hE123);
    step();
    chk("ldr_done_state", 16'(state), 16'h0001);
    chk("ldr_done_retired", retired, 16'd1);
    chk("ldr_done_addr", 16'(imem_addr), 16'h0001);

    // JMP.
    mem[0] = 16'h4055;
    apply_reset();
    step();
    step();
    chk("jmp_addr", 16'(imem_addr), 16'h0055);
    chk("jmp_retired", retired, 16'd1);

    // BZ taken; a non-ARM op in between must not disturb the flag.
    mem[0] = 16'h8000;
    mem[1] = 16'h0000;
    mem[2] = 16'h5010;
    apply_reset();
    step();
    alu_zero = 1'b1;
    step();
    alu_zero = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bz_taken_addr", 16'(imem_addr), 16'h0010);
    chk("bz_taken_retired", retired, 16'd3);

    // BZ not taken.
    mem[1] = 16'h5010;
    mem[2] = 16'h0000;
    alu_zero = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) step();
    chk("bz_fall_addr", 16'(imem_addr), 16'h0002);

    // HALT at pc=4.
    mem[0] = 16'h0000;
    mem[1] = 16'h0000;
    mem[2] = 16'h0000;
    mem[3] = 16'h0000;
    mem[4] = 16'h7000;
    apply_reset();
    for (int i = 0; i < 9; i++) step();
    chk("halt_e1_state", 16'(state), 16'h0002);
    step();
    chk("halt_state", 16'(state), 16'h0000);
    chk("halt_halted", 16'(halted), 16'h0001);
    chk("halt_req", 16'(imem_req), 16'h0000);
    chk("halt_addr", 16'(imem_addr), 16'h0005);
    chk("halt_retired", retired, 16'd4);
    for (int i = 0; i < 20; i++) step();
    chk("halt_hold_state", 16'(state), 16'h0000);
    chk("halt_hold_addr", 16'(imem_addr), 16'h0005);
    chk("halt_hold_retired", retired, 16'd4);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_state", 16'(state), 16'h0001);
    chk("halt_rst_addr", 16'(imem_addr), 16'h0000);
    chk("halt_rst_halted", 16'(halted), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("halt_restart_state", 16'(state), 16'h0002);

    // Asynchronous reset during EXEC2 takes effect without a clock edge.
    mem[0] = 16'hE123;
    apply_reset();
    step();
    step();
    chk("arst_pre_state", 16'(state), 16'h0004);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 16'(state), 16'h0001);
    chk("arst_retired", retired, 16'd0);
    chk("arst_inst", inst, 16'h0000);
    chk("arst_addr", 16'(imem_addr), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // PC wrap on the 4-bit instance starting at pc=15.
    chk("wrap_rst_addr", 16'(imem_addr4), 16'h000F);
    @(negedge clk);
    rst4_n = 1'b1;
    step();
    chk("wrap_e1_addr", 16'(imem_addr4), 16'h0000);
    chk("wrap_e1_state", 16'(state4), 16'h0002);
    step();
    chk("wrap_fetch_addr", 16'(imem_addr4), 16'h0000);
    chk("wrap_fetch_state", 16'(state4), 16'h0001);
    chk("wrap_retired", retired4, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
